uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmitter. It accepts a parallel byte through a valid handshake and latches the byte and its parity configuration. It then walks the output mux through start, data (LSB first), optional parity and stop, one bit per clock. It drives the mux select, the serial data bit, the parity bit and a busy flag. CLK is the bit-rate clock: one CLK period is one bit time.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 106 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-in / mux-control-out bundle between the UART host logic and the frame sequencer.
// The master drives the byte and its parity config; the slave (sequencer) drives the mux controls.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  // Handshake: Data_Valid qualifies P_DATA/PAR_EN/PAR_TYP and is consumed on any rising
  // edge where the sequencer is in IDLE or STOP; at all other edges it is ignored (no queueing).
  // There is no ready: busy is informational and stays high in STOP even though STOP accepts.
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;
  logic [2:0]            dbg_state;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy, dbg_state
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy, dbg_state
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// One CLK period is one bit time; outputs steer the external serialiser mux.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bit_q, par_bit_d;
  logic                  busy_q, busy_d;
  logic                  accept;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bit_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bit_q <= par_bit_d;
      busy_q    <= busy_d;
    end
  end

  // STOP accepts as well as IDLE so back-to-back frames leave no idle bit between them.
  assign accept = bus.Data_Valid && ((state_q == S_IDLE) || (state_q == S_STOP));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bit_d = par_bit_q;

    case (state_q)
      S_IDLE, S_STOP: begin
        if (accept) begin
          state_d   = S_START;
          cnt_d     = '0;
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_DATA;
      S_DATA: begin
        // Counter parks on the last index; the next accept clears it.
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: state_d = S_STOP;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    bus.mux_sel = 2'b01;
    case (state_q)
      S_START:  bus.mux_sel = 2'b00;
      S_DATA:   bus.mux_sel = 2'b10;
      S_PARITY: bus.mux_sel = 2'b11;
      default:  bus.mux_sel = 2'b01;
    endcase
  end

  assign bus.ser_data  = (state_q == S_DATA) ? data_q[cnt_q] : 1'b0;
  assign bus.par_bit   = par_bit_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the driver expands each accepted byte into the expected
// per-bit line trace; an independent monitor pops and compares it every bit time.
module tb_uart_tx_ctrl;
  localparam int DW = 8;

  logic CLK;
  logic RST;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard state ----------------
  // Record = {mux_sel[1:0], ser_data, par_bit} for one bit time.
  logic [3:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         rem = 0;        // frame bit times still to be shown, including the current one
  bit         in_reset = 1'b0;
  logic       model_par = 1'b0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a frame is just a list of line symbols built from the byte.
  task automatic push_frame(input logic [DW-1:0] d, input bit en, input bit typ);
    logic p;
    p = (^d) ^ typ;
    exp_q.push_back({2'b00, 1'b0, p});
    for (int i = 0; i < DW; i++) exp_q.push_back({2'b10, d[i], p});
    if (en) exp_q.push_back({2'b11, 1'b0, p});
    exp_q.push_back({2'b01, 1'b0, p});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit dv, input logic [DW-1:0] d, input bit en, input bit typ);
    bit acc;
    @(negedge CLK);
    bus.Data_Valid = dv;
    bus.P_DATA     = d;
    bus.PAR_EN     = en;
    bus.PAR_TYP    = typ;
    acc = dv && !in_reset && (rem <= 1);
    @(posedge CLK);
    if (acc) begin
      push_frame(d, en, typ);
      rem = DW + 2 + int'(en);
    end else if (rem > 0) begin
      rem--;
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while (rem != target && guard < 64) begin
      idle_cycle();
      guard++;
    end
  endtask

  task automatic mid_reset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    in_reset = 1'b1;
    exp_q.delete();
    rem = 0;
    model_par = 1'b0;
    #1;
    check("async_rst_mux", {2'b00, bus.mux_sel}, 4'b0001);
    check("async_rst_busy", {3'b000, bus.busy}, 4'b0000);
    repeat (3) cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    RST = 1'b0;
    in_reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [3:0] rec;
    forever begin
      @(negedge CLK);
      if (bus.busy) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_busy got=busy,mux=%b exp=idle t=%0t", bus.mux_sel, $time);
        end else begin
          tests--;
          rec = exp_q.pop_front();
          check("frame_bit", {bus.mux_sel, bus.ser_data, bus.par_bit}, rec);
          model_par = rec[0];
        end
      end else begin
        check("idle_line", {bus.mux_sel, bus.ser_data, bus.par_bit}, {2'b01, 1'b0, model_par});
        tests++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL missing_frame got=idle exp=%0d pending bits t=%0t", exp_q.size(), $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    RST            = 1'b1;
    in_reset       = 1'b1;

    // Reset held with random inputs, then 20 quiet cycles.
    repeat (5) cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    RST = 1'b0;
    in_reset = 1'b0;
    repeat (20) idle_cycle();

    // Even parity, no parity, odd parity.
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    run_until(0);
    repeat (2) idle_cycle();
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    run_until(0);
    repeat (2) idle_cycle();
    cycle(1'b1, 8'hA5, 1'b1, 1'b1);
    run_until(0);
    repeat (2) idle_cycle();

    // Lockout: a valid byte during DATA must be dropped.
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    repeat (3) idle_cycle();
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    run_until(0);
    repeat (2) idle_cycle();

    // Back-to-back: second byte offered while STOP is on the line.
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    run_until(1);
    cycle(1'b1, 8'h81, 1'b1, 1'b1);
    run_until(0);
    repeat (2) idle_cycle();

    // Reset during the 4th data bit; nothing may follow without a new valid.
    cycle(1'b1, 8'hC3, 1'b1, 1'b0);
    repeat (4) idle_cycle();
    mid_reset();
    repeat (15) idle_cycle();

    // Randomized traffic with one reset dropped in mid-stream.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      cycle(($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    run_until(0);
    repeat (5) idle_cycle();

    @(negedge CLK);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
